// File: rtl/byte_stream_fifo_src.sv
// First-word-fall-through byte FIFO feeding a valid/ready stream.
// Producer writes via wr_en_i; the consumer drains via valid_o/ready_i.
module byte_stream_fifo_src #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en_i,
    input  logic [DATA_W-1:0]          wr_data_i,
    output logic                       full_o,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       overflow_o,
    input  logic                       clear_i,
    output logic                       valid_o,
    output logic [DATA_W-1:0]          data_o,
    input  logic                       ready_i
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              r_overflow;

    logic w_full;
    logic w_valid;
    logic w_wr_acc;
    logic w_rd_acc;

    // Status is decoded from registered count only, so no path from ready_i/wr_en_i.
    assign w_full   = (r_count == CW'(DEPTH));
    assign w_valid  = (r_count != '0);
    assign w_wr_acc = wr_en_i && !w_full;
    assign w_rd_acc = w_valid && ready_i;

    assign full_o     = w_full;
    assign valid_o    = w_valid;
    assign level_o    = r_count;
    assign overflow_o = r_overflow;
    assign data_o     = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_wr_acc && !clear_i) begin
            r_mem[r_wr_ptr] <= wr_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (clear_i) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (wr_en_i && w_full) begin
                r_overflow <= 1'b1;
            end
            if (w_wr_acc && !w_rd_acc) begin
                r_count <= r_count + CW'(1);
            end else if (w_rd_acc && !w_wr_acc) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

endmodule
